// File: rtl/periph_spi_arbiter.sv
// -----------------------------------------------------------------------------
// periph_spi_arbiter
//
// FPGA-side SPI master that shares the peripheral SPI bus between N_REQ
// internal requesters. Each granted requester gets one fixed-length
// full-duplex transaction (mode 1: CPOL=0, CPHA=1, MSB first) to the chip
// select it names. The word captured from MISO is returned on rdata.
//
// Configuration macro:
//   PERIPH_SPI_RR_EN  defined   -> round-robin arbitration (search starts at
//                                  last winner + 1, pointer updated at grant)
//                     undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester transaction request (level)
//   req_sel    per-requester CS index, requester i at [3i+2:3i]
//   req_data   per-requester write word, requester i at [WIDTH*i +: WIDTH]
//   gnt        one-hot grant, high for the whole transaction
//   done       one-cycle completion pulse to the owning requester
//   err        one-cycle pulse with done when the select was out of range
//   rdata      captured read word, valid from done until the next done
//   busy       high whenever the FSM is not IDLE
//   spi_clk    SCLK (idles low)
//   spi_mosi   serial data out
//   spi_miso   serial data in (already muxed from the selected device)
//   cs_vec     active-low chip selects, at most one low
// -----------------------------------------------------------------------------
module periph_spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_CS    = 8,
    parameter int WIDTH   = 24,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*3-1:0]     req_sel,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   err,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic                   spi_clk,
    output logic                   spi_mosi,
    input  logic                   spi_miso,
    output logic [N_CS-1:0]        cs_vec
);

    localparam int WW      = $clog2(N_REQ);
    localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [N_CS-1:0]    cs_q, cs_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic [WIDTH-1:0]   rx_q, rx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               bad_q, bad_d;   // current transaction has an out-of-range select

`ifdef PERIPH_SPI_RR_EN
    logic [WW-1:0]      ptr_q, ptr_d;   // last winner
`endif

    // Arbitration result (combinational, only consumed in IDLE)
    logic               arb_found;
    logic [WW-1:0]      arb_idx;
    logic [N_REQ-1:0]   arb_onehot;
    logic [2:0]         arb_sel;
    logic [WIDTH-1:0]   arb_data;
    logic               arb_sel_ok;
    logic [N_CS-1:0]    arb_cs;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
`ifdef PERIPH_SPI_RR_EN
        // Walk candidates ptr+1, ptr+2, ... modulo N_REQ; first requester wins.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!arb_found && req[i] &&
                    (i == ((32'(ptr_q) + k) % N_REQ))) begin
                    arb_found = 1'b1;
                    arb_idx   = WW'(i);
                end
            end
        end
`else
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!arb_found && req[i]) begin
                arb_found = 1'b1;
                arb_idx   = WW'(i);
            end
        end
`endif
    end

    always_comb begin
        arb_onehot = '0;
        arb_sel    = '0;
        arb_data   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == WW'(i)) begin
                arb_onehot[i] = 1'b1;
                arb_sel       = req_sel[3*i +: 3];
                arb_data      = req_data[WIDTH*i +: WIDTH];
            end
        end
        arb_sel_ok = (int'(arb_sel) < N_CS);
        arb_cs     = '1;
        for (int unsigned i = 0; i < N_CS; i++) begin
            if (int'(arb_sel) == int'(i)) begin
                arb_cs[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_d    = cs_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        bad_d   = bad_q;
`ifdef PERIPH_SPI_RR_EN
        ptr_d   = ptr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d = arb_onehot;
                    tx_d  = arb_data;
                    rx_d  = '0;
                    cnt_d = '0;
                    bit_d = '0;
                    bad_d = !arb_sel_ok;
`ifdef PERIPH_SPI_RR_EN
                    ptr_d = arb_idx;
`endif
                    if (arb_sel_ok) begin
                        cs_d    = arb_cs;
                        mosi_d  = arb_data[WIDTH-1];
                        state_d = S_SETUP;
                    end else begin
                        // No device selected: bus stays idle, only the gap runs.
                        cs_d    = '1;
                        mosi_d  = 1'b0;
                        state_d = S_GAP;
                    end
                end
            end

            S_SETUP: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;   // first rising edge; MOSI already holds the MSB
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_SHIFT: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: sample MISO into the LSB end.
                        sclk_d = 1'b0;
                        rx_d   = {rx_q[WIDTH-2:0], spi_miso};
                    end else if (bit_q == BW'(WIDTH - 1)) begin
                        // Low half after the last falling edge has elapsed.
                        state_d = S_HOLD;
                    end else begin
                        // Rising edge: present the next bit.
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 1'b1;
                        tx_d   = tx_q << 1;
                        mosi_d = tx_d[WIDTH-1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    cs_d    = '1;
                    mosi_d  = 1'b0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == CW'(CS_GAP - 1)) begin
                    cnt_d   = '0;
                    done_d  = gnt_q;
                    err_d   = bad_q;
                    rdata_d = bad_q ? '0 : rx_q;
                    gnt_d   = '0;
                    bad_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                cs_d    = '1;
                sclk_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            bad_q   <= 1'b0;
`ifdef PERIPH_SPI_RR_EN
            ptr_q   <= WW'(N_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            bad_q   <= bad_d;
`ifdef PERIPH_SPI_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign cs_vec   = cs_q;

endmodule

// File: tb/tb_periph_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_periph_spi_arbiter
//
// Directed bench for periph_spi_arbiter. u_dut uses default parameters with
// MISO looped back to MOSI (or forced high); u_dut4 uses N_CS=4 so that an
// out-of-range select can be exercised.
// -----------------------------------------------------------------------------
module tb_periph_spi_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [3:0]  req;
    logic [11:0] req_sel;
    logic [95:0] req_data;
    logic [3:0]  gnt, done;
    logic        err, busy, spi_clk, spi_mosi, spi_miso;
    logic [23:0] rdata;
    logic [7:0]  cs_vec;
    logic        miso_hi;

    assign spi_miso = miso_hi ? 1'b1 : spi_mosi;

    logic [3:0]  req4;
    logic [11:0] req_sel4;
    logic [95:0] req_data4;
    logic [3:0]  gnt4, done4;
    logic        err4, busy4, spi_clk4, spi_mosi4, spi_miso4;
    logic [23:0] rdata4;
    logic [3:0]  cs_vec4;

    assign spi_miso4 = spi_mosi4;

    int errors = 0;
    int checks = 0;

    periph_spi_arbiter u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_sel  (req_sel),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .cs_vec   (cs_vec)
    );

    periph_spi_arbiter #(.N_CS(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req4),
        .req_sel  (req_sel4),
        .req_data (req_data4),
        .gnt      (gnt4),
        .done     (done4),
        .err      (err4),
        .rdata    (rdata4),
        .busy     (busy4),
        .spi_clk  (spi_clk4),
        .spi_mosi (spi_mosi4),
        .spi_miso (spi_miso4),
        .cs_vec   (cs_vec4)
    );

    task automatic set_req(input int i, input logic [2:0] sel, input logic [23:0] data);
        req_sel[3*i +: 3]   = sel;
        req_data[24*i +: 24] = data;
        req[i]              = 1'b1;
    endtask

    // Called on the falling clk edge where gnt is first visible; returns on the
    // falling edge where done[idx] is seen (or after the cycle budget).
    task automatic watch(input int idx, input logic [7:0] cs_exp,
                         output int cyc, output int falls, output int rises,
                         output logic first_mosi, output int cs_bad);
        logic prev;
        cyc = 0; falls = 0; rises = 0; first_mosi = 1'bx; cs_bad = 0;
        prev = spi_clk;
        while (done[idx] !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (spi_clk === 1'b1 && prev === 1'b0) begin
                if (rises == 0) first_mosi = spi_mosi;
                rises++;
            end
            if (spi_clk === 1'b0 && prev === 1'b1) falls++;
            prev = spi_clk;
            if (cs_vec !== 8'hFF && cs_vec !== cs_exp) cs_bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cs_vec !== 8'hFF) begin errors++; $display("FAIL reset_cs got=%h exp=ff", cs_vec); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", spi_clk); end
        checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", spi_mosi); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done got=%b exp=0000", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=000000", rdata); end
        checks++; if (cs_vec4 !== 4'hF) begin errors++; $display("FAIL reset_cs4 got=%h exp=f", cs_vec4); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc, falls, rises, cs_bad;
        logic fm;
        miso_hi = 1'b0;
        set_req(0, 3'd1, 24'hA5C3F0);
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        checks++; if (cs_vec !== 8'hFD) begin errors++; $display("FAIL single_cs got=%h exp=fd", cs_vec); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        req[0] = 1'b0;
        watch(0, 8'hFD, cyc, falls, rises, fm, cs_bad);
        checks++; if (cyc != 102) begin errors++; $display("FAIL single_latency got=%0d exp=102", cyc); end
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done got=%b exp=0001", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err); end
        checks++; if (rdata !== 24'hA5C3F0) begin errors++; $display("FAIL single_rdata got=%h exp=a5c3f0", rdata); end
        checks++; if (falls != 24) begin errors++; $display("FAIL single_falls got=%0d exp=24", falls); end
        checks++; if (rises != 24) begin errors++; $display("FAIL single_rises got=%0d exp=24", rises); end
        checks++; if (fm !== 1'b1) begin errors++; $display("FAIL single_first_mosi got=%b exp=1", fm); end
        checks++; if (cs_bad != 0) begin errors++; $display("FAIL single_cs_stable got=%0d exp=0", cs_bad); end
        @(negedge clk);
        checks++; if (done !== 4'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0000", done); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL single_gnt_drop got=%b exp=0000", gnt); end
        checks++; if (rdata !== 24'hA5C3F0) begin errors++; $display("FAIL single_rdata_hold got=%h exp=a5c3f0", rdata); end
    endtask

    task automatic test_miso_high();
        int cyc, falls, rises, cs_bad;
        logic fm;
        miso_hi = 1'b1;
        set_req(1, 3'd3, 24'h5A0000);
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL misohi_gnt got=%b exp=0010", gnt); end
        checks++; if (cs_vec !== 8'hF7) begin errors++; $display("FAIL misohi_cs got=%h exp=f7", cs_vec); end
        req[1] = 1'b0;
        watch(1, 8'hF7, cyc, falls, rises, fm, cs_bad);
        checks++; if (cyc != 102) begin errors++; $display("FAIL misohi_latency got=%0d exp=102", cyc); end
        checks++; if (rdata !== 24'hFFFFFF) begin errors++; $display("FAIL misohi_rdata got=%h exp=ffffff", rdata); end
        checks++; if (falls != 24) begin errors++; $display("FAIL misohi_falls got=%0d exp=24", falls); end
        checks++; if (fm !== 1'b0) begin errors++; $display("FAIL misohi_first_mosi got=%b exp=0", fm); end
        checks++; if (cs_bad != 0) begin errors++; $display("FAIL misohi_cs_stable got=%0d exp=0", cs_bad); end
        miso_hi = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        int cyc, edges, cs_bad;
        logic prev;
        // In-range transaction first so rdata4 holds a non-zero word.
        req_sel4[2:0]  = 3'd0;
        req_data4[23:0] = 24'h3C3C3C;
        req4[0] = 1'b1;
        @(negedge clk);
        checks++; if (gnt4 !== 4'b0001) begin errors++; $display("FAIL oor_pre_gnt got=%b exp=0001", gnt4); end
        checks++; if (cs_vec4 !== 4'hE) begin errors++; $display("FAIL oor_pre_cs got=%h exp=e", cs_vec4); end
        req4[0] = 1'b0;
        cyc = 0;
        while (done4[0] !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 102) begin errors++; $display("FAIL oor_pre_latency got=%0d exp=102", cyc); end
        checks++; if (rdata4 !== 24'h3C3C3C) begin errors++; $display("FAIL oor_pre_rdata got=%h exp=3c3c3c", rdata4); end
        @(negedge clk);
        req_sel4[8:6]    = 3'd5;
        req_data4[71:48] = 24'hFFFFFF;
        req4[2] = 1'b1;
        @(negedge clk);
        checks++; if (gnt4 !== 4'b0100) begin errors++; $display("FAIL oor_gnt got=%b exp=0100", gnt4); end
        req4[2] = 1'b0;
        cyc = 0; edges = 0; cs_bad = 0; prev = spi_clk4;
        while (done4[2] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (spi_clk4 !== prev) edges++;
            prev = spi_clk4;
            if (cs_vec4 !== 4'hF) cs_bad++;
        end
        checks++; if (cyc != 2) begin errors++; $display("FAIL oor_latency got=%0d exp=2", cyc); end
        checks++; if (done4 !== 4'b0100) begin errors++; $display("FAIL oor_done got=%b exp=0100", done4); end
        checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", err4); end
        checks++; if (rdata4 !== 24'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=000000", rdata4); end
        checks++; if (edges != 0) begin errors++; $display("FAIL oor_sclk_edges got=%0d exp=0", edges); end
        checks++; if (cs_bad != 0) begin errors++; $display("FAIL oor_cs_high got=%0d exp=0", cs_bad); end
        @(negedge clk);
        checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got=%b exp=0", err4); end
    endtask

    task automatic test_late_request();
        int cyc, hi_run, falls, rises, cs_bad;
        logic fm;
        set_req(0, 3'd1, 24'h00FF00);
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL late_gnt0 got=%b exp=0001", gnt); end
        req[0] = 1'b0;
        cyc = 0; hi_run = 0;
        while (done[0] !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            hi_run = (cs_vec === 8'hFF) ? hi_run + 1 : 0;
            if (cyc == 20) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL late_busy got=%b exp=1", busy); end
                set_req(3, 3'd2, 24'hC0FFEE);
            end
        end
        checks++; if (cyc != 102) begin errors++; $display("FAIL late_latency0 got=%0d exp=102", cyc); end
        checks++; if (rdata !== 24'h00FF00) begin errors++; $display("FAIL late_rdata0 got=%h exp=00ff00", rdata); end
        @(negedge clk);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL late_gnt3 got=%b exp=1000", gnt); end
        checks++; if (cs_vec !== 8'hFB) begin errors++; $display("FAIL late_cs3 got=%h exp=fb", cs_vec); end
        checks++; if (hi_run != 3) begin errors++; $display("FAIL late_cs_high_cycles got=%0d exp=3", hi_run); end
        req[3] = 1'b0;
        watch(3, 8'hFB, cyc, falls, rises, fm, cs_bad);
        checks++; if (cyc != 102) begin errors++; $display("FAIL late_latency3 got=%0d exp=102", cyc); end
        checks++; if (rdata !== 24'hC0FFEE) begin errors++; $display("FAIL late_rdata3 got=%h exp=c0ffee", rdata); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int cyc, falls, rises, cs_bad, done_seen;
        logic prev, fm;
        set_req(1, 3'd2, 24'h800001);
        @(negedge clk);
        req[1] = 1'b0;
        cyc = 0; falls = 0; prev = spi_clk;
        while (!(falls == 10 && spi_clk === 1'b1) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (spi_clk === 1'b0 && prev === 1'b1) falls++;
            prev = spi_clk;
        end
        checks++; if (cyc >= 400) begin errors++; $display("FAIL rst_mid_reach_bit10 got=timeout exp=bit10"); end
        rst_n = 1'b0;
        #1;
        checks++; if (cs_vec !== 8'hFF) begin errors++; $display("FAIL rst_mid_cs got=%h exp=ff", cs_vec); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("FAIL rst_mid_sclk got=%b exp=0", spi_clk); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL rst_mid_gnt got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (rdata !== 24'h0) begin errors++; $display("FAIL rst_mid_rdata got=%h exp=000000", rdata); end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 4'b0) done_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 4'b0) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_seen); end
        set_req(1, 3'd3, 24'h123456);
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rst_mid_regnt got=%b exp=0010", gnt); end
        req[1] = 1'b0;
        watch(1, 8'hF7, cyc, falls, rises, fm, cs_bad);
        checks++; if (cyc != 102) begin errors++; $display("FAIL rst_mid_latency got=%0d exp=102", cyc); end
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL rst_mid_done got=%b exp=0010", done); end
        checks++; if (rdata !== 24'h123456) begin errors++; $display("FAIL rst_mid_rdata2 got=%h exp=123456", rdata); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int order[5];
        int exp_order[5];
        int n, cyc, idx;
        logic [3:0] prev_gnt;
`ifdef PERIPH_SPI_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        // Fresh reset so the arbitration pointer starts at N_REQ-1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 24'h111111 * (i + 1));
        n = 0; cyc = 0; prev_gnt = gnt;
        while (n < 5 && cyc < 700) begin
            @(negedge clk);
            cyc++;
            if (prev_gnt === 4'b0 && gnt !== 4'b0) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (gnt[i] === 1'b1) idx = i;
                order[n] = idx;
                n++;
            end
            prev_gnt = gnt;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL contention_count got=%0d exp=5", n); end
        for (int i = 0; i < 5; i++) begin
            if (i < n) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL contention_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]);
                end
            end
        end
        req = '0;
        cyc = 0;
        while (done === 4'b0 && cyc < 200) begin @(negedge clk); cyc++; end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_idle got=%b exp=0", busy); end
    endtask

    initial begin
        req       = '0;
        req_sel   = '0;
        req_data  = '0;
        req4      = '0;
        req_sel4  = '0;
        req_data4 = '0;
        miso_hi   = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_single();
        test_miso_high();
        test_out_of_range();
        test_late_request();
        test_reset_mid_shift();
        test_contention();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
